// File: rtl/rv32_instr_encoder.sv
// RV32IM instruction assembler: turns decoded fields back into instruction words
// and hands them, with sequential word addresses, to the instruction-memory writer.
package rv32_encoder_pkg;

  typedef enum logic [4:0] {
    ALUCTRL_ADD, ALUCTRL_SUB, ALUCTRL_SLL, ALUCTRL_SLT, ALUCTRL_SLTU,
    ALUCTRL_XOR, ALUCTRL_SRL, ALUCTRL_SRA, ALUCTRL_OR, ALUCTRL_AND,
    ALUCTRL_MUL, ALUCTRL_MULH, ALUCTRL_MULHSU, ALUCTRL_MULHU,
    ALUCTRL_DIV, ALUCTRL_DIVU, ALUCTRL_REM, ALUCTRL_REMU,
    ALUCTRL_BEQ, ALUCTRL_BNE, ALUCTRL_BLT, ALUCTRL_BGE, ALUCTRL_BLTU, ALUCTRL_BGEU
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_LOAD, FMT_STORE, FMT_BRANCH, FMT_JAL, FMT_JALR, FMT_AUIPC
  } fmt_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0, ERR_ILLEGAL = 2'd1, ERR_RANGE = 2'd2, ERR_ALIGN = 2'd3
  } err_e;

endpackage

module rv32_instr_encoder
  import rv32_encoder_pkg::*;
#(
  parameter int BITS   = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [BITS-1:0]   in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BITS-1:0]   out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              full,
  output logic              err_valid,
  output logic [1:0]        err_code
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  function automatic logic in_rng(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  int          imm_s;
  logic [2:0]  alu_f3, b_f3;
  logic [6:0]  alu_f7;
  logic        r_ok, i_ok, b_ok, shift_op;
  logic        legal, range_ok, aligned;
  logic [BITS-1:0] enc;
  err_e        code;
  logic        accept;

  assign imm_s    = in_imm;
  assign r_ok     = in_op <= 5'(ALUCTRL_REMU);
  assign i_ok     = (in_op < 5'(ALUCTRL_MUL)) && (in_op != 5'(ALUCTRL_SUB));
  assign b_ok     = (in_op >= 5'(ALUCTRL_BEQ)) && (in_op <= 5'(ALUCTRL_BGEU));
  assign shift_op = (in_op == 5'(ALUCTRL_SLL)) || (in_op == 5'(ALUCTRL_SRL)) ||
                    (in_op == 5'(ALUCTRL_SRA));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    alu_f3 = 3'b000;
    alu_f7 = 7'b0000000;
    b_f3   = 3'b000;
    case (alu_ctrl_e'(in_op))
      ALUCTRL_SUB:  alu_f7 = 7'b0100000;
      ALUCTRL_SLL:  alu_f3 = 3'b001;
      ALUCTRL_SLT:  alu_f3 = 3'b010;
      ALUCTRL_SLTU: alu_f3 = 3'b011;
      ALUCTRL_XOR:  alu_f3 = 3'b100;
      ALUCTRL_SRL:  alu_f3 = 3'b101;
      ALUCTRL_SRA:  begin alu_f3 = 3'b101; alu_f7 = 7'b0100000; end
      ALUCTRL_OR:   alu_f3 = 3'b110;
      ALUCTRL_AND:  alu_f3 = 3'b111;
      ALUCTRL_MUL, ALUCTRL_MULH, ALUCTRL_MULHSU, ALUCTRL_MULHU,
      ALUCTRL_DIV, ALUCTRL_DIVU, ALUCTRL_REM, ALUCTRL_REMU: begin
        // M-extension funct3 runs 000..111 in ALUCTRL order
        alu_f7 = 7'b0000001;
        alu_f3 = 3'(in_op - 5'(ALUCTRL_MUL));
      end
      ALUCTRL_BNE:  b_f3 = 3'b001;
      ALUCTRL_BLT:  b_f3 = 3'b100;
      ALUCTRL_BGE:  b_f3 = 3'b101;
      ALUCTRL_BLTU: b_f3 = 3'b110;
      ALUCTRL_BGEU: b_f3 = 3'b111;
      default: ;
    endcase
  end

  always_comb begin
    enc      = '0;
    legal    = 1'b1;
    range_ok = 1'b1;
    aligned  = 1'b1;
    case (fmt_e'(in_fmt))
      FMT_R: begin
        legal = r_ok;
        enc   = {alu_f7, in_rs2, in_rs1, alu_f3, in_rd, OP_R};
      end
      FMT_I: begin
        legal = i_ok;
        if (shift_op) begin
          range_ok = in_rng(imm_s, 0, 31);
          enc      = {alu_f7, in_imm[4:0], in_rs1, alu_f3, in_rd, OP_I};
        end else begin
          range_ok = in_rng(imm_s, -2048, 2047);
          enc      = {in_imm[11:0], in_rs1, alu_f3, in_rd, OP_I};
        end
      end
      FMT_LOAD: begin
        range_ok = in_rng(imm_s, -2048, 2047);
        enc      = {in_imm[11:0], in_rs1, 3'b010, in_rd, OP_LOAD};
      end
      FMT_STORE: begin
        range_ok = in_rng(imm_s, -2048, 2047);
        enc      = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OP_STORE};
      end
      FMT_BRANCH: begin
        legal    = b_ok;
        range_ok = in_rng(imm_s, -4096, 4094);
        aligned  = !in_imm[0];
        enc      = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, b_f3,
                    in_imm[4:1], in_imm[11], OP_BRANCH};
      end
      FMT_JAL: begin
        range_ok = in_rng(imm_s, -1048576, 1048574);
        aligned  = !in_imm[0];
        enc      = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
      end
      FMT_JALR: begin
        range_ok = in_rng(imm_s, -2048, 2047);
        enc      = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
      end
      FMT_AUIPC: begin
        range_ok = (in_imm[11:0] == 12'd0);
        enc      = {in_imm[31:12], in_rd, OP_AUIPC};
      end
      default: ;
    endcase
  end

  assign code = !legal    ? ERR_ILLEGAL :
                !range_ok ? ERR_RANGE   :
                !aligned  ? ERR_ALIGN   : ERR_NONE;

  assign in_ready = !full && !clear && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_addr  <= '0;
      full      <= 1'b0;
      err_valid <= 1'b0;
      err_code  <= 2'd0;
    end else if (clear) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_addr  <= '0;
      full      <= 1'b0;
      err_valid <= 1'b0;
    end else begin
      err_valid <= 1'b0;
      if (out_valid && out_ready) begin
        out_addr <= out_addr + 1'b1;
        if (&out_addr) full <= 1'b1;
      end
      if (accept) begin
        if (code != ERR_NONE) begin
          err_valid <= 1'b1;
          err_code  <= code;
          out_valid <= 1'b0;
        end else begin
          out_valid <= 1'b1;
          out_instr <= enc;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
